// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, op-codes and FSM state type for the
//                arbitrated ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int OPND_W = 2;   // operand width
    localparam int RES_W  = 4;   // result width (results wrap mod 16)
    localparam int OP_W   = 4;   // op-code width

    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Registered 2-bit operand ALU with a 4-bit wrapping result.
//                The result register loads only while en is high, so it holds
//                its value once the operation has completed.
//  Revision    : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] w_a;
    logic [RES_W-1:0] w_b;
    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] res_q;

    assign w_a = {{(RES_W-OPND_W){1'b0}}, a};
    assign w_b = {{(RES_W-OPND_W){1'b0}}, b};

    // Select the arithmetic for the current op; all paths wrap at RES_W bits.
    always_comb begin
        res_d = res_q;
        if (en) begin
            case (op)
                OP_MUL:  res_d = w_a * w_b;
                OP_ADD:  res_d = w_a + w_b;
                default: res_d = w_a - w_b + 4'd1;
            endcase
        end
    end

    // Result register; contents are don't-care until the first operation.
    always_ff @(posedge clk) begin
        res_q <= res_d;
    end

    assign result = res_q;

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one registered ALU between two requesters. One
//                operation in flight: IDLE accepts, EXEC computes, RESP
//                holds the result until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int FAIR_RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [RES_W-1:0]  resp_data
);

    state_t            state_d, state_q;
    logic [OPND_W-1:0] a_d, a_q;
    logic [OPND_W-1:0] b_d, b_q;
    logic [OP_W-1:0]   op_d, op_q;
    logic              id_d, id_q;

    logic              w_grant;   // 0 = requester 0, 1 = requester 1
    logic              w_idle;
    logic              w_hs;
    logic              w_hs_id;
    logic [RES_W-1:0]  w_alu_res;

    assign w_idle = (state_q == IDLE);

    generate
        if (FAIR_RR != 0) begin : g_rr
            logic last_d, last_q;

            // Tie goes to whichever requester was not granted last time.
            always_comb begin
                if (req0_valid && req1_valid) begin
                    w_grant = ~last_q;
                end else begin
                    w_grant = req1_valid;
                end
            end

            // Pointer moves only on an actual handshake, never on a bare grant.
            always_comb begin
                last_d = last_q;
                if (w_hs) begin
                    last_d = w_hs_id;
                end
            end

            // Pointer resets to 1 so requester 0 wins the first tie.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    last_q <= 1'b1;
                end else begin
                    last_q <= last_d;
                end
            end
        end else begin : g_fixed
            // Requester 0 always wins when it is asking.
            always_comb begin
                w_grant = ~req0_valid;
            end
        end
    endgenerate

    assign req0_ready = w_idle & req0_valid & ~w_grant;
    assign req1_ready = w_idle & req1_valid &  w_grant;
    assign w_hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_hs_id    = req1_ready;

    // Next-state and operand capture for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    a_d     = w_hs_id ? req1_a  : req0_a;
                    b_d     = w_hs_id ? req1_b  : req0_b;
                    op_d    = w_hs_id ? req1_op : req0_op;
                    id_d    = w_hs_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
        end
    end

    alu u_alu (
        .clk    (clk),
        .en     (state_q == EXEC),
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (w_alu_res)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_data  = w_alu_res;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter. A round-robin
//                and a fixed-priority instance share the same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic       resp_ready;

    logic       r0_ready, r1_ready, resp_valid, resp_id;
    logic [3:0] resp_data;
    logic       f0_ready, f1_ready, f_resp_valid, f_resp_id;
    logic [3:0] f_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR_RR(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    alu_arbiter #(.FAIR_RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(f1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(f_resp_valid), .resp_ready(resp_ready),
        .resp_id(f_resp_id), .resp_data(f_resp_data)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a request and wait (bounded) for its handshake; returns at
    // posedge+1 of the handshake edge, i.e. with the DUT in EXEC.
    task automatic send(input bit id, input logic [1:0] a, input logic [1:0] b,
                        input logic [3:0] op);
        bit got;
        int k;
        got = 1'b0;
        k   = 0;
        @(negedge clk);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        while (!got && k < 20) begin
            #1;
            if ((id == 1'b0) ? r0_ready : r1_ready) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("send_handshake", 16'(got), 16'd1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Full transaction: result must appear one edge after the handshake edge.
    task automatic run_op(input string tag, input bit id, input logic [1:0] a,
                          input logic [1:0] b, input logic [3:0] op,
                          input logic [3:0] exp);
        send(id, a, b, op);
        check({tag, "_exec_idle"}, 16'(resp_valid), 16'd0);
        @(posedge clk);
        #1;
        check({tag, "_resp"}, 16'({resp_valid, resp_id, resp_data}), 16'({1'b1, id, exp}));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_done"}, 16'(resp_valid), 16'd0);
    endtask

    initial begin
        int g_rr[$];
        int g_fp[$];
        int first_cyc;
        int second_cyc;
        int both_hi;

        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b0;
        #2;
        check("reset_state", 16'({resp_valid, resp_id, r0_ready, r1_ready}), 16'd0);
        check("reset_state_fp", 16'({f_resp_valid, f_resp_id, f0_ready, f1_ready}), 16'd0);
        req1_valid = 1'b1;
        #1;
        check("reset_idle_ready", 16'({r0_ready, r1_ready}), 16'b01);
        req1_valid = 1'b0;
        do_reset();

        // Basic arithmetic and latency
        run_op("mul_3x3", 1'b0, 2'd3, 2'd3, 4'd2, 4'd9);
        run_op("wrap_sub", 1'b1, 2'd0, 2'd3, 4'd0, 4'd14);
        run_op("add_3p3", 1'b1, 2'd3, 2'd3, 4'd3, 4'd6);
        run_op("def_op0", 1'b0, 2'd2, 2'd1, 4'd0, 4'd2);
        run_op("def_op1", 1'b1, 2'd2, 2'd1, 4'd1, 4'd2);
        run_op("def_op4", 1'b0, 2'd2, 2'd1, 4'd4, 4'd2);
        run_op("def_op15", 1'b1, 2'd2, 2'd1, 4'd15, 4'd2);
        run_op("mul_2x3", 1'b0, 2'd2, 2'd3, 4'd2, 4'd6);

        // Arbitration with both requesters continuously valid
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 2'd1; req0_b = 2'd1; req0_op = 4'd3;
        req1_valid = 1'b1; req1_a = 2'd2; req1_b = 2'd2; req1_op = 4'd2;
        first_cyc  = -1;
        second_cyc = -1;
        both_hi    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (r0_ready || r1_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                else if (second_cyc < 0) second_cyc = cyc;
            end
            if (r0_ready) g_rr.push_back(0);
            if (r1_ready) g_rr.push_back(1);
            if (f0_ready) g_fp.push_back(0);
            if (f1_ready) g_fp.push_back(1);
            if ((r0_ready && r1_ready) || (f0_ready && f1_ready)) both_hi++;
            if (g_rr.size() >= 4 && g_fp.size() >= 4) break;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("one_ready_max", 16'(both_hi), 16'd0);
        check("rr_count", 16'(g_rr.size() >= 4), 16'd1);
        check("fp_count", 16'(g_fp.size() >= 4), 16'd1);
        if (g_rr.size() >= 4) begin
            check("rr_grant0", 16'(g_rr[0]), 16'd0);
            check("rr_grant1", 16'(g_rr[1]), 16'd1);
            check("rr_grant2", 16'(g_rr[2]), 16'd0);
            check("rr_grant3", 16'(g_rr[3]), 16'd1);
        end
        if (g_fp.size() >= 4) begin
            check("fp_grant0", 16'(g_fp[0]), 16'd0);
            check("fp_grant1", 16'(g_fp[1]), 16'd0);
            check("fp_grant2", 16'(g_fp[2]), 16'd0);
            check("fp_grant3", 16'(g_fp[3]), 16'd0);
        end
        check("issue_interval", 16'(second_cyc - first_cyc), 16'd3);

        // Backpressure in RESP with a pending request
        do_reset();
        send(1'b0, 2'd3, 2'd3, 4'd3);
        req1_valid = 1'b1; req1_a = 2'd1; req1_b = 2'd2; req1_op = 4'd3;
        check("exec_no_ready", 16'({r0_ready, r1_ready}), 16'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 16'({resp_valid, resp_id, resp_data, r0_ready, r1_ready}),
                  16'({1'b1, 1'b0, 4'd6, 1'b0, 1'b0}));
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp_release", 16'({resp_valid, r0_ready, r1_ready}), 16'b001);
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("cancel_no_resp", 16'({resp_valid, r0_ready, r1_ready}), 16'd0);
        end

        // Reset while an operation is in EXEC
        do_reset();
        run_op("pre_rst", 1'b0, 2'd1, 2'd1, 4'd3, 4'd2);
        send(1'b0, 2'd1, 2'd1, 4'd2);
        rst = 1'b1;
        #1;
        check("rst_exec_valid", 16'({resp_valid, resp_id}), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_resp", 16'(resp_valid), 16'd0);
        end
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_first_grant", 16'({r0_ready, r1_ready}), 16'b10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR_RR, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  2 each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 operation code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meaning for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  1  index of requester that issued the result.
REQ-012 resp_data  output  4  ALU result.

Function
REQ-013 The block SHALL share one registered ALU (one-cycle latency, result in 4 bits) between two requesters, one operation in flight at a time.
REQ-014 ALU arithmetic SHALL be: op==2 -> a*b; op==3 -> a+b; any other op -> (a-b+1) mod 16; all results mod 16, operands unsigned.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 IDLE: reqN_ready SHALL be 1 only for the granted requester and only while state==IDLE and reqN_valid==1; at most one ready high per cycle.
REQ-017 On a handshake edge (valid&&ready): latch a, b, op, id into operand registers driving the ALU; state -> EXEC.
REQ-018 EXEC: lasts exactly one cycle; ALU registers its result at the end of it; state -> RESP.
REQ-019 RESP: resp_valid=1, resp_data=ALU output, resp_id=latched id, all stable until resp_ready==1; on that edge state -> IDLE.
REQ-020 Latency: handshake edge T -> resp_valid high from T+2; with resp_ready held 1, minimum issue interval is 3 cycles.
REQ-021 No request SHALL be accepted in EXEC or RESP (both readys 0); requests held by valid remain pending.
REQ-022 Arbitration (FAIR_RR=1): only one valid -> grant it; both valid -> grant requester not granted last; last-grant pointer updates on handshake only.
REQ-023 Arbitration (FAIR_RR=0): both valid -> always grant requester 0.
REQ-024 Grant SHALL be computed combinationally from current valids in IDLE; a valid dropping before handshake cancels nothing stored.
REQ-025 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-026 rst high SHALL asynchronously force state=IDLE, resp_valid=0, resp_id=0, req0_ready/req1_ready follow IDLE rules, last-grant pointer = 1 (requester 0 wins first tie).
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is emitted for it.
REQ-028 resp_data is don't-care while resp_valid==0; ALU result register need not be reset.

Structure
REQ-029 Shared package alu_pkg SHALL hold op-code constants (OP_MUL=2, OP_ADD=3), the FSM state enum, and operand/result width constants (2, 4).
REQ-030 The existing alu module SHALL be instantiated as the single sub-module; arbiter adds no arithmetic of its own.

Verification
REQ-031 Single req0: a=3,b=3,op=2 accepted at edge T -> resp_valid at T+2, resp_data=9, resp_id=0.
REQ-032 Wrap: req1 a=0,b=3,op=0 -> resp_data=14, resp_id=1; a=3,b=3,op=3 -> 6.
REQ-033 Both valid continuously, resp_ready=1, FAIR_RR=1 -> grants 0,1,0,1 after reset; FAIR_RR=0 -> grants 0,0,0.
REQ-034 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/data/id stable, both readys 0, then release -> IDLE next cycle.
REQ-035 Reset asserted mid-EXEC -> resp_valid stays 0, next acceptance granted to requester 0 when both valid.
REQ-036 Ops 0,1,4,15 with a=2,b=1 -> all produce 2 (default path).
